// File: rtl/tx_frame_pkg.sv
// Shared definitions for the SPI response frame transmitter: FSM states, header layout, SEQ width.
// The CHK state exists only when RESP_CHECKSUM_EN is defined.
package tx_frame_pkg;

  localparam int SEQ_W        = 4;
  localparam logic [7:0] HDR_TAG_DEFAULT = 8'hA5;
  localparam int HDR_TAG_LSB  = 8;
  localparam int HDR_SEQ_LSB  = 4;
  localparam int HDR_DROP_BIT = 1;
  localparam int HDR_BUSY_BIT = 0;

`ifdef RESP_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_HDR = 3'd1, ST_DATA = 3'd2, ST_CHK = 3'd3, ST_DONE = 3'd4
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_HDR = 3'd1, ST_DATA = 3'd2, ST_DONE = 3'd4
  } tx_state_e;
`endif

  function automatic logic [15:0] build_header(input logic [7:0] tag,
                                               input logic [SEQ_W-1:0] seq,
                                               input logic drop,
                                               input logic busy);
    logic [15:0] h;
    h = '0;
    h[HDR_TAG_LSB +: 8]     = tag;
    h[HDR_SEQ_LSB +: SEQ_W] = seq;
    h[HDR_DROP_BIT]         = drop;
    h[HDR_BUSY_BIT]         = busy;
    return h;
  endfunction

endpackage

// File: rtl/rising_edge_det.sv
// One-register rising-edge detector; pulse is high while din=1 and its registered copy is 0.
module rising_edge_det (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic pulse
);

  logic prev_q, prev_d;

  always_comb prev_d = din;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign pulse = din & ~prev_q;

endmodule

// File: rtl/response_tx_16bit.sv
// Snapshots the photon count on a READ_DATA rising edge and streams a header plus
// COUNT_W/16 data words over valid/ready. Define RESP_CHECKSUM_EN to append an XOR check word.
module response_tx_16bit
  import tx_frame_pkg::*;
#(
  parameter int         COUNT_W = 32,
  parameter logic [7:0] HDR_TAG = HDR_TAG_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               READ_DATA,
  input  logic [COUNT_W-1:0] COUNT_VALUE,
  input  logic               COUNT_BUSY,
  input  logic               TX_READY,
  output logic [15:0]        TX_WORD,
  output logic               TX_VALID,
  output logic               BUSY,
  output logic               FRAME_DONE
);

  localparam int         N        = COUNT_W / 16;
  localparam logic [2:0] LAST_IDX = 3'(N - 1);

  tx_state_e          state_q, state_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               drop_q, drop_d;
  logic [2:0]         idx_q, idx_d;
  logic [15:0]        tx_word_q, tx_word_d;
  logic               tx_valid_q, tx_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [COUNT_W-1:0] snap_count_q, snap_count_d;
  logic               snap_busy_q, snap_busy_d;
  logic               snap_drop_q, snap_drop_d;
`ifdef RESP_CHECKSUM_EN
  logic [15:0]        chk_q, chk_d;
`endif
  logic               req_pulse;
  logic               xfer;

  rising_edge_det u_req_edge (
    .CLK   (CLK),
    .RST_N (RST_N),
    .din   (READ_DATA),
    .pulse (req_pulse)
  );

  // Data word idx, most-significant word first.
  function automatic logic [15:0] word_at(input logic [COUNT_W-1:0] v, input logic [2:0] idx);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < N; i++)
      if (idx == 3'(i)) w = v[16*(N-1-i) +: 16];
    return w;
  endfunction

  assign xfer = tx_valid_q & TX_READY;

  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    drop_d       = drop_q;
    idx_d        = idx_q;
    tx_word_d    = tx_word_q;
    tx_valid_d   = tx_valid_q;
    frame_done_d = 1'b0;
    snap_count_d = snap_count_q;
    snap_busy_d  = snap_busy_q;
    snap_drop_d  = snap_drop_q;
`ifdef RESP_CHECKSUM_EN
    chk_d        = xfer ? (chk_q ^ tx_word_q) : chk_q;
`endif

    if (req_pulse && state_q != ST_IDLE) drop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req_pulse) begin
          snap_count_d = COUNT_VALUE;
          snap_busy_d  = COUNT_BUSY;
          snap_drop_d  = drop_q;
          drop_d       = 1'b0;
`ifdef RESP_CHECKSUM_EN
          chk_d        = '0;
`endif
          state_d      = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!tx_valid_q) begin
          tx_word_d  = build_header(HDR_TAG, seq_q, snap_drop_q, snap_busy_q);
          tx_valid_d = 1'b1;
        end else if (xfer) begin
          idx_d     = 3'd0;
          tx_word_d = word_at(snap_count_q, 3'd0);
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
`ifdef RESP_CHECKSUM_EN
            tx_word_d    = chk_q ^ tx_word_q;
            state_d      = ST_CHK;
`else
            tx_valid_d   = 1'b0;
            frame_done_d = 1'b1;
            state_d      = ST_DONE;
`endif
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_word_d = word_at(snap_count_q, idx_q + 3'd1);
          end
        end
      end
`ifdef RESP_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) begin
          tx_valid_d   = 1'b0;
          frame_done_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        seq_d   = seq_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      seq_q        <= '0;
      drop_q       <= 1'b0;
      idx_q        <= '0;
      tx_word_q    <= '0;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      drop_q       <= drop_d;
      idx_q        <= idx_d;
      tx_word_q    <= tx_word_d;
      tx_valid_q   <= tx_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Snapshot and checksum are only read after being loaded in IDLE, so they need no reset.
  always_ff @(posedge CLK) begin
    snap_count_q <= snap_count_d;
    snap_busy_q  <= snap_busy_d;
    snap_drop_q  <= snap_drop_d;
`ifdef RESP_CHECKSUM_EN
    chk_q        <= chk_d;
`endif
  end

  assign TX_WORD    = tx_word_q;
  assign TX_VALID   = tx_valid_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign FRAME_DONE = frame_done_q;

endmodule
